// File: rtl/dbus_mailbox.sv
// dbus_mailbox: memory-mapped mailbox on the CPU data bus.
// Two word FIFOs: TX (CPU stores -> external consumer) and RX (external producer -> CPU loads).
// Register window of four words: TXDATA, RXDATA, STATUS, CONTROL.
// Loads are answered combinationally from registered state; every state change happens on
// the clock edge that ends the bus cycle.

module dbus_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
    parameter int unsigned DEPTH     = 8
) (
    input  logic        iCLK,
    input  logic        iRST,

    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,

    output logic        oTxValid,
    output logic [31:0] oTxData,
    input  logic        iTxReady,

    input  logic        iRxValid,
    input  logic [31:0] iRxData,
    output logic        oRxReady
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_RXDATA  = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_CONTROL = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   r_tx_mem [DEPTH];
    logic [31:0]   r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wptr;
    logic [AW-1:0] r_tx_rptr;
    logic [CW-1:0] r_tx_count;
    logic [AW-1:0] r_rx_wptr;
    logic [AW-1:0] r_rx_rptr;
    logic [CW-1:0] r_rx_count;
    logic          r_tx_overflow;
    logic          r_rx_underflow;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic          w_hit;
    logic [1:0]    w_off;
    logic          w_rd_hit;
    logic          w_wr_hit;

    // Effective (reset-masked) view of the registered state, so outputs read as reset
    // values for the whole time iRST is low, not only after the first reset edge.
    logic [CW-1:0] w_tx_count;
    logic [CW-1:0] w_rx_count;
    logic          w_tx_overflow;
    logic          w_rx_underflow;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_rx_empty;

    logic          w_tx_valid;
    logic          w_rx_ready;
    logic          w_tx_pop;
    logic          w_tx_push_req;
    logic          w_tx_push;
    logic          w_tx_ovf_set;
    logic          w_rx_pop_req;
    logic          w_rx_pop;
    logic          w_rx_udf_set;
    logic          w_rx_push;

    logic          w_ctl_wr;
    logic          w_clr_sticky;
    logic          w_tx_flush;
    logic          w_rx_flush;

    logic [31:0]   w_tx_wdata;
    logic [31:0]   w_status;

    logic [AW-1:0] w_tx_wptr_nxt;
    logic [AW-1:0] w_tx_rptr_nxt;
    logic [CW-1:0] w_tx_count_nxt;
    logic [AW-1:0] w_rx_wptr_nxt;
    logic [AW-1:0] w_rx_rptr_nxt;
    logic [CW-1:0] w_rx_count_nxt;
    logic          w_tx_overflow_nxt;
    logic          w_rx_underflow_nxt;

    // Byte-offset bits of the address are deliberately ignored.
    logic          w_unused;
    assign w_unused = ^DwAddress[1:0];

    // ------------------------------------------------------------------
    // Address decode and status flags
    // ------------------------------------------------------------------
    // Decode the bus access and derive FIFO occupancy flags.
    always_comb begin
        w_hit    = (DwAddress[31:4] == BASE_ADDR[31:4]);
        w_off    = DwAddress[3:2];
        w_rd_hit = DwReadEnable & w_hit;
        w_wr_hit = DwWriteEnable & w_hit;

        w_tx_count     = iRST ? r_tx_count : '0;
        w_rx_count     = iRST ? r_rx_count : '0;
        w_tx_overflow  = iRST & r_tx_overflow;
        w_rx_underflow = iRST & r_rx_underflow;

        w_tx_full  = (w_tx_count == FULL_CNT);
        w_tx_empty = (w_tx_count == '0);
        w_rx_full  = (w_rx_count == FULL_CNT);
        w_rx_empty = (w_rx_count == '0);
    end

    // Transfer qualifiers for both FIFOs and the CONTROL register.
    always_comb begin
        w_tx_valid = iRST & ~w_tx_empty;
        w_rx_ready = iRST & ~w_rx_full;

        w_tx_pop      = w_tx_valid & iTxReady;
        w_tx_push_req = w_wr_hit & (w_off == OFF_TXDATA);
        // Full is judged before the edge, so a same-edge pop never makes room.
        w_tx_push     = w_tx_push_req & ~w_tx_full;
        w_tx_ovf_set  = w_tx_push_req & w_tx_full;

        w_rx_push     = iRxValid & w_rx_ready;
        w_rx_pop_req  = w_rd_hit & (w_off == OFF_RXDATA);
        w_rx_pop      = w_rx_pop_req & ~w_rx_empty;
        w_rx_udf_set  = w_rx_pop_req & w_rx_empty;

        w_ctl_wr     = w_wr_hit & (w_off == OFF_CONTROL) & DwByteEnable[0];
        w_clr_sticky = w_ctl_wr & DwWriteData[0];
        w_tx_flush   = w_ctl_wr & DwWriteData[1];
        w_rx_flush   = w_ctl_wr & DwWriteData[2];
    end

    // Zero the byte lanes that are not enabled on a TXDATA store.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_tx_wdata[8*b +: 8] = DwByteEnable[b] ? DwWriteData[8*b +: 8] : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // TX pointers and count; a flush discards any concurrent push or pop.
    always_comb begin
        w_tx_wptr_nxt  = r_tx_wptr;
        w_tx_rptr_nxt  = r_tx_rptr;
        w_tx_count_nxt = r_tx_count;
        if (w_tx_flush) begin
            w_tx_wptr_nxt  = '0;
            w_tx_rptr_nxt  = '0;
            w_tx_count_nxt = '0;
        end else begin
            if (w_tx_push) begin
                w_tx_wptr_nxt = r_tx_wptr + AW'(1);
            end
            if (w_tx_pop) begin
                w_tx_rptr_nxt = r_tx_rptr + AW'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   w_tx_count_nxt = r_tx_count + CW'(1);
                2'b01:   w_tx_count_nxt = r_tx_count - CW'(1);
                default: w_tx_count_nxt = r_tx_count;
            endcase
        end
    end

    // RX pointers and count; a flush discards any concurrent push or pop.
    always_comb begin
        w_rx_wptr_nxt  = r_rx_wptr;
        w_rx_rptr_nxt  = r_rx_rptr;
        w_rx_count_nxt = r_rx_count;
        if (w_rx_flush) begin
            w_rx_wptr_nxt  = '0;
            w_rx_rptr_nxt  = '0;
            w_rx_count_nxt = '0;
        end else begin
            if (w_rx_push) begin
                w_rx_wptr_nxt = r_rx_wptr + AW'(1);
            end
            if (w_rx_pop) begin
                w_rx_rptr_nxt = r_rx_rptr + AW'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   w_rx_count_nxt = r_rx_count + CW'(1);
                2'b01:   w_rx_count_nxt = r_rx_count - CW'(1);
                default: w_rx_count_nxt = r_rx_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear still registers.
    always_comb begin
        w_tx_overflow_nxt  = w_tx_ovf_set | (r_tx_overflow & ~w_clr_sticky);
        w_rx_underflow_nxt = w_rx_udf_set | (r_rx_underflow & ~w_clr_sticky);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Control state with synchronous active-low reset.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_tx_wptr      <= '0;
            r_tx_rptr      <= '0;
            r_tx_count     <= '0;
            r_rx_wptr      <= '0;
            r_rx_rptr      <= '0;
            r_rx_count     <= '0;
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else begin
            r_tx_wptr      <= w_tx_wptr_nxt;
            r_tx_rptr      <= w_tx_rptr_nxt;
            r_tx_count     <= w_tx_count_nxt;
            r_rx_wptr      <= w_rx_wptr_nxt;
            r_rx_rptr      <= w_rx_rptr_nxt;
            r_rx_count     <= w_rx_count_nxt;
            r_tx_overflow  <= w_tx_overflow_nxt;
            r_rx_underflow <= w_rx_underflow_nxt;
        end
    end

    // FIFO storage; not reset, contents are only visible through valid pointers.
    always_ff @(posedge iCLK) begin
        if (iRST && w_tx_push && !w_tx_flush) begin
            r_tx_mem[r_tx_wptr] <= w_tx_wdata;
        end
        if (iRST && w_rx_push && !w_rx_flush) begin
            r_rx_mem[r_rx_wptr] <= iRxData;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Assemble the STATUS word from the reset-masked state.
    always_comb begin
        w_status        = '0;
        w_status[0]     = w_tx_full;
        w_status[1]     = w_tx_empty;
        w_status[2]     = w_rx_full;
        w_status[3]     = w_rx_empty;
        w_status[4]     = w_tx_overflow;
        w_status[5]     = w_rx_underflow;
        w_status[15:8]  = 8'(w_tx_count);
        w_status[23:16] = 8'(w_rx_count);
    end

    // Combinational load data; write-only registers and misses read as zero.
    always_comb begin
        DwReadData = '0;
        if (w_rd_hit) begin
            case (w_off)
                OFF_RXDATA: DwReadData = w_rx_empty ? 32'h0 : r_rx_mem[r_rx_rptr];
                OFF_STATUS: DwReadData = w_status;
                default:    DwReadData = '0;
            endcase
        end
    end

    // External handshake outputs depend only on registered state and reset.
    always_comb begin
        oTxValid = w_tx_valid;
        oTxData  = w_tx_valid ? r_tx_mem[r_tx_rptr] : 32'h0;
        oRxReady = w_rx_ready;
    end

endmodule

// File: tb/tb_dbus_mailbox.sv
// Testbench for dbus_mailbox: directed scenarios followed by random traffic.
// The driver computes expected outputs from a queue-based model and pushes them into
// scoreboard queues; an independent monitor pops and compares on the falling edge.

module tb_dbus_mailbox;

    localparam logic [31:0] BASE  = 32'hFF20_0000;
    localparam int          DEPTH = 8;

    logic        iCLK;
    logic        iRST;
    logic        DwReadEnable;
    logic        DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [31:0] DwReadData;
    logic        oTxValid;
    logic [31:0] oTxData;
    logic        iTxReady;
    logic        iRxValid;
    logic [31:0] iRxData;
    logic        oRxReady;

    dbus_mailbox #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .DwReadEnable (DwReadEnable),
        .DwWriteEnable(DwWriteEnable),
        .DwByteEnable (DwByteEnable),
        .DwAddress    (DwAddress),
        .DwWriteData  (DwWriteData),
        .DwReadData   (DwReadData),
        .oTxValid     (oTxValid),
        .oTxData      (oTxData),
        .iTxReady     (iTxReady),
        .iRxValid     (iRxValid),
        .iRxData      (iRxData),
        .oRxReady     (oRxReady)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic        txv;
        logic [31:0] txd;
        logic        rxr;
    } ctl_t;

    int          total;
    int          bad;
    bit          running;
    logic [31:0] exp_rd_q[$];
    ctl_t        exp_ctl_q[$];
    ctl_t        mon_e;

    // Reference model state
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    logic        m_ovf;
    logic        m_udf;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_tx.size() == DEPTH);
        s[1]     = (m_tx.size() == 0);
        s[2]     = (m_rx.size() == DEPTH);
        s[3]     = (m_rx.size() == 0);
        s[4]     = m_ovf;
        s[5]     = m_udf;
        s[15:8]  = 8'(m_tx.size());
        s[23:16] = 8'(m_rx.size());
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard.
    always @(negedge iCLK) begin
        if (running) begin
            if (exp_ctl_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ctl_queue: got empty expected entry at %0t", $time);
            end else begin
                mon_e = exp_ctl_q.pop_front();
                check("tx_valid", {31'b0, oTxValid}, {31'b0, mon_e.txv});
                check("tx_data", oTxData, mon_e.txd);
                check("rx_ready", {31'b0, oRxReady}, {31'b0, mon_e.rxr});
            end
            if (DwReadEnable) begin
                if (exp_rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_queue: got empty expected entry at %0t", $time);
                end else begin
                    check("read_data", DwReadData, exp_rd_q.pop_front());
                end
            end
        end
    end

    // One bus cycle: drive, predict, let the edge happen, then advance the model.
    task automatic cyc(input logic rst, input logic re, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input logic txr,
                       input logic rxv, input logic [31:0] rxd,
                       input logic ovr = 1'b0, input logic [31:0] ov = 32'h0);
        logic        hit;
        logic [1:0]  off;
        logic [31:0] v;
        logic [31:0] masked;
        ctl_t        e;
        bit          tx_full, rx_empty, tx_pop, rx_push, push_req, ctl, rx_rd;

        iRST          = rst;
        DwReadEnable  = re;
        DwWriteEnable = we;
        DwByteEnable  = be;
        DwAddress     = addr;
        DwWriteData   = wd;
        iTxReady      = txr;
        iRxValid      = rxv;
        iRxData       = rxd;

        hit = (addr[31:4] == BASE[31:4]);
        off = addr[3:2];

        e.txv = rst && (m_tx.size() != 0);
        e.txd = e.txv ? m_tx[0] : 32'h0;
        e.rxr = rst && (m_rx.size() < DEPTH);
        exp_ctl_q.push_back(e);

        if (re) begin
            v = 32'h0;
            if (hit && off == 2'd1) v = (rst && m_rx.size() != 0) ? m_rx[0] : 32'h0;
            if (hit && off == 2'd2) v = rst ? m_status() : 32'h0000_000A;
            if (ovr) v = ov;
            exp_rd_q.push_back(v);
        end

        @(posedge iCLK);

        if (!rst) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) masked[8*b +: 8] = be[b] ? wd[8*b +: 8] : 8'h00;
            tx_full  = (m_tx.size() == DEPTH);
            rx_empty = (m_rx.size() == 0);
            tx_pop   = (m_tx.size() != 0) && txr;
            rx_push  = (m_rx.size() < DEPTH) && rxv;
            push_req = we && hit && off == 2'd0;
            ctl      = we && hit && off == 2'd3 && be[0];
            rx_rd    = re && hit && off == 2'd1;
            if (ctl && wd[0]) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (push_req && tx_full) m_ovf = 1'b1;
            if (rx_rd && rx_empty) m_udf = 1'b1;
            if (ctl && wd[1]) m_tx.delete();
            else begin
                if (tx_pop) m_tx.delete(0);
                if (push_req && !tx_full) m_tx.push_back(masked);
            end
            if (ctl && wd[2]) m_rx.delete();
            else begin
                if (rx_rd && !rx_empty) m_rx.delete(0);
                if (rx_push) m_rx.push_back(rxd);
            end
        end
        #1;
    endtask

    task automatic rd_status(input logic [31:0] want);
        cyc(1, 1, 0, 4'h0, BASE + 32'h8, 32'h0, 0, 0, 32'h0, 1, want);
    endtask

    initial begin
        logic [1:0]  r_off;
        logic [1:0]  r_lo;
        logic [31:0] r_addr;

        total = 0;
        bad   = 0;
        running = 0;
        m_ovf = 0;
        m_udf = 0;
        iRST = 0; DwReadEnable = 0; DwWriteEnable = 0; DwByteEnable = 0;
        DwAddress = 0; DwWriteData = 0; iTxReady = 0; iRxValid = 0; iRxData = 0;

        @(posedge iCLK);
        #1;
        running = 1;

        // Reset, including a STATUS read while reset is asserted
        repeat (2) cyc(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        cyc(0, 1, 0, 4'h0, BASE + 32'h8, 32'h0, 0, 0, 32'h0, 1, 32'h0000_000A);
        rd_status(32'h0000_000A);

        // Byte-enable masking on a TX store
        cyc(1, 0, 1, 4'b0101, BASE, 32'h1234_5678, 0, 0, 32'h0);
        rd_status(32'h0000_0108);
        cyc(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        rd_status(32'h0000_000A);

        // TX overflow with the consumer stalled
        for (int i = 0; i < 9; i++) cyc(1, 0, 1, 4'hF, BASE, 32'hC0DE_0000 + i, 0, 0, 32'h0);
        rd_status(32'h0000_0819);
        cyc(1, 0, 1, 4'h1, BASE + 32'hC, 32'h1, 0, 0, 32'h0);
        rd_status(32'h0000_0809);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        rd_status(32'h0000_000A);

        // RX fill, ordered drain, then underflow
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hA000_0000 + i);
        cyc(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++)
            cyc(1, 1, 0, 4'h0, BASE + 32'h4, 32'h0, 0, 0, 32'h0, 1, 32'hA000_0000 + i);
        cyc(1, 1, 0, 4'h0, BASE + 32'h4, 32'h0, 0, 0, 32'h0, 1, 32'h0);
        rd_status(32'h0000_002A);
        cyc(1, 0, 1, 4'h1, BASE + 32'hC, 32'h1, 0, 0, 32'h0);

        // RX steady state: pop and push on the same edge across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hB000_0000 + i);
        for (int i = 0; i < 20; i++)
            cyc(1, 1, 0, 4'h0, BASE + 32'h4, 32'h0, 0, 1, 32'hB100_0000 + i);
        rd_status(32'h0003_0002);

        // TX flush while the consumer is accepting
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 4'hF, BASE, 32'h5500_0000 + i, 0, 0, 32'h0);
        cyc(1, 0, 1, 4'h1, BASE + 32'hC, 32'h2, 1, 0, 32'h0);
        rd_status(32'h0003_0002);

        // Reset mid-transfer
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 4'hF, BASE, 32'h6600_0000 + i, 0, 1, 32'h7700_0000 + i);
        cyc(0, 0, 1, 4'hF, BASE, 32'h6600_00FF, 1, 1, 32'h7700_00FF);
        rd_status(32'h0000_000A);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r_off = 2'($urandom_range(0, 3));
            r_lo  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) r_addr = BASE ^ (32'h1 << $urandom_range(4, 31));
            else                           r_addr = BASE | {28'h0, r_off, r_lo};
            cyc(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), 4'($urandom), r_addr, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        running = 0;
        total++;
        if (exp_ctl_q.size() != 0 || exp_rd_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d/%0d entries expected 0/0",
                     exp_ctl_q.size(), exp_rd_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
